ysyx_22041461_ex_issue_buf: RTL and testbench

//   Decode->execute issue buffer. Registers ALU operands, ALU control code, PC and rd from decode,

---
 rtl/ysyx_22041461_ex_issue_buf_if.sv | 32 +++
 rtl/ysyx_22041461_ex_issue_buf.sv | 102 ++++++++++
 tb/tb_ysyx_22041461_ex_issue_buf.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041461_ex_issue_buf_if.sv
// Handshake bundle between decode and the EX issue buffer and between the buffer and the ALU.
// The buffer is the slave on both sides. The environment (decode plus EX) is the master.
interface ysyx_22041461_ex_issue_buf_if #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_src1;
  logic [XLEN-1:0]   in_src2;
  logic [CTRL_W-1:0] in_ctrl_ALU;
  logic [XLEN-1:0]   in_pc;
  logic [4:0]        in_rd;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_src1;
  logic [XLEN-1:0]   out_src2;
  logic [CTRL_W-1:0] out_ctrl_ALU;
  logic [XLEN-1:0]   out_pc;
  logic [4:0]        out_rd;

  modport slave (
    input  in_valid, in_src1, in_src2, in_ctrl_ALU, in_pc, in_rd, out_ready,
    output in_ready, out_valid, out_src1, out_src2, out_ctrl_ALU, out_pc, out_rd
  );

  modport master (
    output in_valid, in_src1, in_src2, in_ctrl_ALU, in_pc, in_rd, out_ready,
    input  in_ready, out_valid, out_src1, out_src2, out_ctrl_ALU, out_pc, out_rd
  );
endinterface

// File: rtl/ysyx_22041461_ex_issue_buf.sv
// Decode-to-execute issue buffer with a main entry and a skid entry, which gives full throughput.
// in_ready comes from registered state only. The buffer supports flush and counts back-pressure cycles.
module ysyx_22041461_ex_issue_buf #(
   parameter int XLEN   = 64,
   parameter int CTRL_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   ysyx_22041461_ex_issue_buf_if.slave    bus,
   output logic [CNT_W-1:0]               stall_cnt
);

   // State bit 0 is main_valid and state bit 1 is skid_valid.
   // Because of this encoding, the handshake outputs come straight from flops.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } state_e;

   typedef struct packed {
      logic [XLEN-1:0]   src1;
      logic [XLEN-1:0]   src2;
      logic [CTRL_W-1:0] ctrl;
      logic [XLEN-1:0]   pc;
      logic [4:0]        rd;
   } entry_t;

   state_e state_q;
   entry_t main_q;
   entry_t skid_q;
   entry_t in_e;
   logic   main_valid;
   logic   skid_valid;
   logic   accept;
   logic   consume;

   always_comb begin
      in_e.src1 = bus.in_src1;
      in_e.src2 = bus.in_src2;
      in_e.ctrl = bus.in_ctrl_ALU;
      in_e.pc   = bus.in_pc;
      in_e.rd   = bus.in_rd;
   end

   assign main_valid = state_q[0];
   assign skid_valid = state_q[1];
   assign accept     = bus.in_valid & ~skid_valid;
   assign consume    = main_valid & bus.out_ready;

   assign bus.in_ready     = ~skid_valid;
   assign bus.out_valid    = main_valid;
   assign bus.out_src1     = main_q.src1;
   assign bus.out_src2     = main_q.src2;
   assign bus.out_ctrl_ALU = main_valid ? main_q.ctrl : '0;
   assign bus.out_pc       = main_q.pc;
   assign bus.out_rd       = main_q.rd;

   // NOTE: state uses non-blocking assignments so that every branch sees the pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= EMPTY;
         // NOTE: the entry registers are reset on purpose, so that out_* read as zero after reset.
         main_q    <= '0;
         skid_q    <= '0;
         stall_cnt <= '0;
      end else begin
         if (main_valid && !bus.out_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);

         // Flush drops the incoming beat and both entries. Stored data are left stale.
         if (flush) begin
            state_q <= EMPTY;
         end else begin
            case (state_q)
               EMPTY: if (accept) begin
                  main_q  <= in_e;
                  state_q <= ONE;
               end
               ONE: begin
                  if (accept && consume) begin
                     main_q <= in_e;
                  end else if (accept) begin
                     skid_q  <= in_e;
                     state_q <= FULL;
                  end else if (consume) begin
                     state_q <= EMPTY;
                  end
               end
               FULL: if (consume) begin
                  main_q  <= skid_q;
                  state_q <= ONE;
               end
               default: state_q <= EMPTY;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22041461_ex_issue_buf.sv
// Self-checking bench for the EX issue buffer.
// A FIFO queue holds the beats accepted but not yet consumed, and it models the buffer occupancy.
module tb_ysyx_22041461_ex_issue_buf;

   typedef struct packed {
      logic [63:0] src1;
      logic [63:0] src2;
      logic [4:0]  ctrl;
      logic [63:0] pc;
      logic [4:0]  rd;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        flush4 = 1'b0;
   logic [31:0] stall_cnt;
   logic [3:0]  stall_cnt4;

   ent_t        q[$];
   int unsigned sc_model = 0;
   int          tests = 0;
   int          fails = 0;

   ysyx_22041461_ex_issue_buf_if #(.XLEN(64), .CTRL_W(5)) bif ();
   ysyx_22041461_ex_issue_buf_if #(.XLEN(64), .CTRL_W(5)) bif4 ();

   ysyx_22041461_ex_issue_buf #(.XLEN(64), .CTRL_W(5), .CNT_W(32)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .bus(bif), .stall_cnt(stall_cnt)
   );

   ysyx_22041461_ex_issue_buf #(.XLEN(64), .CTRL_W(5), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .flush(flush4), .bus(bif4), .stall_cnt(stall_cnt4)
   );

   always #5 clk = ~clk;

   function automatic ent_t mk(input int i);
      ent_t e;
      e.src1 = 64'hFFFF_FFFF_8000_0000 + 64'(i);
      e.src2 = 64'(i + 4);
      e.ctrl = 5'(5'b01011 + i);
      e.pc   = 64'h8000_0000 + 64'(i * 4);
      e.rd   = 5'(i + 1);
      return e;
   endfunction

   // One clock cycle. It drives inputs at the negedge, checks against the model,
   // advances the model, and then steps to the next negedge.
   task automatic tick(input bit iv, input ent_t d, input bit ordy, input bit fl);
      bit   acc;
      bit   con;
      ent_t got;
      bif.in_valid    = iv;
      bif.in_src1     = d.src1;
      bif.in_src2     = d.src2;
      bif.in_ctrl_ALU = d.ctrl;
      bif.in_pc       = d.pc;
      bif.in_rd       = d.rd;
      bif.out_ready   = ordy;
      flush           = fl;
      #1;
      tests++;
      if (bif.out_valid !== (q.size() != 0)) begin
         fails++;
         $display("FAIL out_valid: got %b want %b", bif.out_valid, q.size() != 0);
      end
      tests++;
      if (bif.in_ready !== (q.size() < 2)) begin
         fails++;
         $display("FAIL in_ready: got %b want %b", bif.in_ready, q.size() < 2);
      end
      tests++;
      if (stall_cnt !== sc_model) begin
         fails++;
         $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, sc_model);
      end
      tests++;
      if (q.size() != 0) begin
         got = '{bif.out_src1, bif.out_src2, bif.out_ctrl_ALU, bif.out_pc, bif.out_rd};
         if (got !== q[0]) begin
            fails++;
            $display("FAIL out_data: got %h want %h", got, q[0]);
         end
      end else if (bif.out_ctrl_ALU !== 5'b00000) begin
         fails++;
         $display("FAIL bubble_ctrl: got %b want 00000", bif.out_ctrl_ALU);
      end
      acc = iv && (q.size() < 2);
      con = (q.size() != 0) && ordy;
      if ((q.size() != 0) && !ordy) sc_model++;
      if (con) void'(q.pop_front());
      if (acc) q.push_back(d);
      if (fl) q.delete();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) tick(1'b0, '0, ordy, 1'b0);
   endtask

   task automatic test_reset;
      bif.in_valid = 1'b0;
      bif.out_ready = 1'b0;
      bif4.in_valid = 1'b0;
      bif4.out_ready = 1'b0;
      bif4.in_src1 = '0; bif4.in_src2 = '0; bif4.in_ctrl_ALU = '0; bif4.in_pc = '0; bif4.in_rd = '0;
      repeat (2) @(negedge clk);
      tests++;
      if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1 || bif.out_ctrl_ALU !== 5'b0) begin
         fails++;
         $display("FAIL reset_hs: got v=%b r=%b c=%b want v=0 r=1 c=0",
                  bif.out_valid, bif.in_ready, bif.out_ctrl_ALU);
      end
      tests++;
      if (bif.out_src1 !== 64'h0 || bif.out_pc !== 64'h0 || bif.out_rd !== 5'h0 || stall_cnt !== 32'h0) begin
         fails++;
         $display("FAIL reset_data: got src1=%h pc=%h rd=%h sc=%0d want all 0",
                  bif.out_src1, bif.out_pc, bif.out_rd, stall_cnt);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_stream;
      for (int i = 0; i < 8; i++) tick(1'b1, mk(i), 1'b1, 1'b0);
      idle(2, 1'b1);
   endtask

   task automatic test_back_to_back_pressure;
      int unsigned sc0;
      sc0 = sc_model;
      tick(1'b1, mk(20), 1'b0, 1'b0);
      tick(1'b1, mk(21), 1'b0, 1'b0);
      tick(1'b1, mk(22), 1'b0, 1'b0);
      tick(1'b1, mk(22), 1'b0, 1'b0);
      tick(1'b1, mk(22), 1'b1, 1'b0);
      tick(1'b1, mk(22), 1'b1, 1'b0);
      idle(2, 1'b1);
      tests++;
      if (stall_cnt - sc0 !== 32'd3) begin
         fails++;
         $display("FAIL stall_delta: got %0d want 3", stall_cnt - sc0);
      end
   endtask

   task automatic test_flush;
      tick(1'b1, mk(30), 1'b0, 1'b0);
      tick(1'b1, mk(31), 1'b0, 1'b0);
      tick(1'b1, mk(32), 1'b0, 1'b1);
      tick(1'b1, mk(33), 1'b1, 1'b0);
      idle(2, 1'b1);
   endtask

   task automatic test_bubble;
      idle(3, 1'b0);
      idle(1, 1'b1);
   endtask

   task automatic test_reset_mid;
      tick(1'b1, mk(40), 1'b0, 1'b0);
      tick(1'b1, mk(41), 1'b0, 1'b0);
      bif.in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      tests++;
      if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1 || bif.out_ctrl_ALU !== 5'b0) begin
         fails++;
         $display("FAIL reset_mid: got v=%b r=%b c=%b want v=0 r=1 c=0",
                  bif.out_valid, bif.in_ready, bif.out_ctrl_ALU);
      end
      tests++;
      if (stall_cnt !== 32'h0) begin
         fails++;
         $display("FAIL reset_mid_cnt: got %0d want 0", stall_cnt);
      end
      q.delete();
      sc_model = 0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tick(1'b1, mk(42), 1'b1, 1'b0);
      idle(1, 1'b1);
   endtask

   task automatic test_saturation;
      bif4.in_valid = 1'b1;
      bif4.in_src1 = 64'h1234;
      bif4.in_ctrl_ALU = 5'b00101;
      bif4.out_ready = 1'b0;
      @(negedge clk);
      bif4.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      tests++;
      if (stall_cnt4 !== 4'hA) begin
         fails++;
         $display("FAIL stall_mid4: got %h want a", stall_cnt4);
      end
      repeat (10) @(negedge clk);
      tests++;
      if (stall_cnt4 !== 4'hF) begin
         fails++;
         $display("FAIL stall_sat4: got %h want f", stall_cnt4);
      end
      tests++;
      if (bif4.out_valid !== 1'b1 || bif4.out_src1 !== 64'h1234 || bif4.out_ctrl_ALU !== 5'b00101) begin
         fails++;
         $display("FAIL hold4: got v=%b src1=%h c=%b want v=1 src1=1234 c=00101",
                  bif4.out_valid, bif4.out_src1, bif4.out_ctrl_ALU);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_stream;
      test_back_to_back_pressure;
      test_flush;
      test_bubble;
      test_reset_mid;
      test_saturation;
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
